// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction fetch: PC sequencing, redirect/flush, fault stop, decode FIFO
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        halted
);
    localparam int                PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [31:0]       LAST_PC = 32'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {ST_RUN, ST_FAULT} state_t;

    state_t             state, state_next;
    logic [31:0]        pc, pc_next;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        fifo_inst  [FIFO_DEPTH];
    logic [31:0]        fifo_pc    [FIFO_DEPTH];
    logic               fifo_fault [FIFO_DEPTH];

    logic               fetch_fault, fetch_ok, pop, push, push_fault;
    logic [31:0]        push_inst;

    assign fetch_fault = (pc[1:0] != 2'b00) || (pc > LAST_PC);
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign fetch_ok    = (state == ST_RUN) && !redirect_valid && ((count < DEPTH_C) || pop);

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        push_inst  = imem_data;
        push_fault = 1'b0;
        if (redirect_valid) begin
            pc_next    = redirect_pc;
            state_next = ST_RUN;
        end else if (fetch_ok) begin
            push = 1'b1;
            if (fetch_fault) begin
                // Fault entry carries a NOP so decode never sees garbage bits
                push_inst  = 32'h0000_0000;
                push_fault = 1'b1;
                state_next = ST_FAULT;
            end else begin
                pc_next = pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (!push && pop) count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr]  <= push_inst;
            fifo_pc[wr_ptr]    <= pc;
            fifo_fault[wr_ptr] <= push_fault;
        end
    end

    assign imem_addr  = pc;
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? fifo_inst[rd_ptr]  : 32'h0000_0000;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]    : 32'h0000_0000;
    assign inst_fault = inst_valid ? fifo_fault[rd_ptr] : 1'b0;
    assign halted     = (state == ST_FAULT);
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - directed self-checking bench for mips_fetch_unit
module tb_mips_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        halted;

    int checks = 0;
    int failures = 0;

    logic [31:0] rom [256];

    mips_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(1024), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault), .halted(halted)
    );

    always #5 clk = ~clk;

    assign imem_data = (imem_addr[31:10] == 22'd0) ? rom[imem_addr[9:2]] : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
        checks++; if (inst_pc !== 32'h0 || inst_fault !== 1'b0) begin failures++; $display("FAIL reset_pc_fault got=%h/%b exp=0/0", inst_pc, inst_fault); end
        checks++; if (halted !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_halt_addr got=%b/%h exp=0/0", halted, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_inst [3];
        exp_inst[0] = 32'h0000_8020; exp_inst[1] = 32'h2011_000A; exp_inst[2] = 32'h2012_0014;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) || inst !== exp_inst[i] || halted !== 1'b0)
            begin failures++; $display("FAIL seq_%0d got v=%b pc=%h inst=%h h=%b exp v=1 pc=%h inst=%h h=0", i, inst_valid, inst_pc, inst, halted, 32'(i * 4), exp_inst[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_addr got=%h exp=00000008", imem_addr); end
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_8020 || inst_pc !== 32'h0) begin failures++; $display("FAIL bp_head got v=%b inst=%h pc=%h exp v=1 inst=00008020 pc=0", inst_valid, inst, inst_pc); end
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) || inst !== rom[i])
            begin failures++; $display("FAIL bp_drain_%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", i, inst_valid, inst_pc, inst, 32'(i * 4), rom[i]); end
            step();
        end
    endtask

    task automatic test_redirect_full();
        do_reset();
        inst_ready = 1'b0;
        step(); step();
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h54;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble got=%b exp=0", inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h54 || inst !== 32'h8D2C_0000) begin failures++; $display("FAIL redir_target got v=%b pc=%h inst=%h exp v=1 pc=54 inst=8d2c0000", inst_valid, inst_pc, inst); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h58 || inst !== rom[22]) begin failures++; $display("FAIL redir_next got v=%b pc=%h inst=%h exp v=1 pc=58 inst=%h", inst_valid, inst_pc, inst, rom[22]); end
    endtask

    task automatic test_fault(input logic [31:0] bad_pc);
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = bad_pc;
        step();
        redirect_valid = 1'b0;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== bad_pc || inst_fault !== 1'b1 || inst !== 32'h0) begin failures++; $display("FAIL fault_entry_%h got v=%b pc=%h f=%b inst=%h exp v=1 f=1 inst=0", bad_pc, inst_valid, inst_pc, inst_fault, inst); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL fault_halted_%h got=%b exp=1", bad_pc, halted); end
        step(); step();
        checks++; if (inst_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== bad_pc) begin failures++; $display("FAIL fault_stop_%h got v=%b h=%b addr=%h exp v=0 h=1 addr=%h", bad_pc, inst_valid, halted, imem_addr, bad_pc); end
        redirect_valid = 1'b1; redirect_pc = 32'h74;
        step();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL fault_clear_%h got h=%b v=%b exp h=0 v=0", bad_pc, halted, inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h74 || inst !== 32'h0800_0015 || inst_fault !== 1'b0) begin failures++; $display("FAIL fault_recover_%h got v=%b pc=%h inst=%h f=%b exp v=1 pc=74 inst=08000015 f=0", bad_pc, inst_valid, inst_pc, inst, inst_fault); end
    endtask

    task automatic test_redirect_with_pop();
        do_reset();
        inst_ready = 1'b1;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rpop_flush got=%b exp=0", inst_valid); end
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20 || inst !== rom[8]) begin failures++; $display("FAIL rpop_target got v=%b pc=%h inst=%h exp v=1 pc=20 inst=%h", inst_valid, inst_pc, inst, rom[8]); end
    endtask

    task automatic test_async_reset();
        do_reset();
        inst_ready = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL async_rst got v=%b addr=%h exp v=0 addr=0", inst_valid, imem_addr); end
        step();
        rst = 1'b0; inst_ready = 1'b1;
        step();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0000_8020) begin failures++; $display("FAIL async_restart got v=%b pc=%h inst=%h exp v=1 pc=0 inst=00008020", inst_valid, inst_pc, inst); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA500_0000 | 32'(i << 2);
        rom[0]  = 32'h0000_8020;
        rom[1]  = 32'h2011_000A;
        rom[2]  = 32'h2012_0014;
        rom[21] = 32'h8D2C_0000;
        rom[22] = 32'h01AE_4820;
        rom[29] = 32'h0800_0015;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_full();
        test_fault(32'h3FE);
        test_fault(32'h400);
        test_redirect_with_pop();
        test_async_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
